// File: rtl/rom_loader_if.sv
// SDRAM write channel of the ROM loader: one outstanding 16-bit word write, req held until ack.
`timescale 1ns/1ps
interface rom_loader_if;
    logic        mem_req;
    logic [21:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_wstrb;
    logic        mem_ack;

    modport master (output mem_req, mem_addr, mem_wdata, mem_wstrb, input mem_ack);
    modport slave  (input mem_req, mem_addr, mem_wdata, mem_wstrb, output mem_ack);
endinterface

// File: rtl/rom_loader.sv
// ROM loader: captures the 64-byte prefix, packs ROM bytes into words and writes them to SDRAM.
// Define ROM_LOADER_CHECKSUM_EN to build the running byte checksum; otherwise checksum reads 0.
`timescale 1ns/1ps
module rom_loader #(
    parameter logic [21:0] ROM_BASE   = 22'h000000,
    parameter logic [23:0] MAX_BYTES  = 24'h600000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         rom_loading,
    input  logic [7:0]   rom_do,
    input  logic         rom_do_valid,
    rom_loader_if.master mem,
    output logic [7:0]   map_mode,
    output logic [7:0]   cart_type,
    output logic [7:0]   rom_size_code,
    output logic [7:0]   ram_size_code,
    output logic         header_valid,
    output logic [23:0]  rom_bytes,
    output logic         busy,
    output logic         load_done,
    output logic         overflow,
    output logic [15:0]  checksum
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] DEPTH_W = FIFO_DEPTH[PW:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_DATA,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t        state;
    logic          loading_q;
    logic [5:0]    hdr_cnt;
    logic [23:0]   rom_idx;
    logic          pend_valid;
    logic [7:0]    pend_byte;
    logic [21:0]   word_idx;

    logic [15:0]   fifo_data [FIFO_DEPTH];
    logic [1:0]    fifo_strb [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   fifo_cnt;

    logic          rise;
    logic          fall;
    logic          data_byte;
    logic          byte_keep;
    logic          tail;
    logic          push_req;
    logic [15:0]   push_word;
    logic [1:0]    push_strb;
    logic          fifo_full;
    logic          pop;
    logic          push_ok;
    logic          push_drop;

    assign rise      = rom_loading & ~loading_q;
    assign fall      = ~rom_loading & loading_q;
    assign data_byte = (state == S_DATA) && rom_do_valid && !rise;
    assign byte_keep = data_byte && (rom_idx < MAX_BYTES);
    assign tail      = (state == S_DATA) && fall;

    // A strobe coinciding with the fall is folded in first, so at most one word is pushed per cycle.
    always_comb begin
        push_req  = 1'b0;
        push_word = 16'h0000;
        push_strb = 2'b00;
        if (byte_keep && pend_valid) begin
            push_req  = 1'b1;
            push_word = {rom_do, pend_byte};
            push_strb = 2'b11;
        end else if (tail && byte_keep) begin
            push_req  = 1'b1;
            push_word = {8'h00, rom_do};
            push_strb = 2'b01;
        end else if (tail && pend_valid) begin
            push_req  = 1'b1;
            push_word = {8'h00, pend_byte};
            push_strb = 2'b01;
        end
    end

    assign fifo_full = (fifo_cnt == DEPTH_W);
    assign pop       = !mem.mem_req && (fifo_cnt != '0) && !rise;
    assign push_ok   = push_req && (!fifo_full || pop);
    assign push_drop = push_req && !push_ok;

    // NOTE: the word storage has no reset; wr_ptr/rd_ptr/fifo_cnt alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_data[wr_ptr] <= push_word;
            fifo_strb[wr_ptr] <= push_strb;
        end
    end

    // NOTE: resetn is synchronous, so it is tested inside the clocked block, not in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= S_IDLE;
            loading_q     <= 1'b0;
            hdr_cnt       <= '0;
            rom_idx       <= '0;
            pend_valid    <= 1'b0;
            pend_byte     <= '0;
            word_idx      <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_cnt      <= '0;
            mem.mem_req   <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            mem.mem_wstrb <= '0;
            map_mode      <= '0;
            cart_type     <= '0;
            rom_size_code <= '0;
            ram_size_code <= '0;
            header_valid  <= 1'b0;
            rom_bytes     <= '0;
            busy          <= 1'b0;
            load_done     <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            loading_q <= rom_loading;
            load_done <= 1'b0;

            // A write in flight at restart is left alone until its ack arrives.
            if (pop) begin
                mem.mem_req   <= 1'b1;
                mem.mem_addr  <= ROM_BASE + word_idx;
                mem.mem_wdata <= fifo_data[rd_ptr];
                mem.mem_wstrb <= fifo_strb[rd_ptr];
                word_idx      <= word_idx + 22'd1;
            end else if (mem.mem_ack) begin
                mem.mem_req   <= 1'b0;
            end

            if (rise) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                fifo_cnt <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + 1'b1;
                if (pop)     rd_ptr <= rd_ptr + 1'b1;
                case ({push_ok, pop})
                    2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                    2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                    default: ;
                endcase
            end

            if (rise) begin
                state        <= S_HEADER;
                busy         <= 1'b1;
                hdr_cnt      <= rom_do_valid ? 6'd1 : 6'd0;
                rom_idx      <= '0;
                rom_bytes    <= '0;
                header_valid <= 1'b0;
                overflow     <= 1'b0;
                pend_valid   <= 1'b0;
                pend_byte    <= '0;
                word_idx     <= '0;
            end else begin
                case (state)
                    S_HEADER: begin
                        if (rom_do_valid) begin
                            hdr_cnt <= hdr_cnt + 6'd1;
                            case (hdr_cnt)
                                6'h15:   map_mode      <= rom_do;
                                6'h16:   cart_type     <= rom_do;
                                6'h17:   rom_size_code <= rom_do;
                                6'h18:   ram_size_code <= rom_do;
                                default: ;
                            endcase
                            if (hdr_cnt == 6'd63) begin
                                header_valid <= 1'b1;
                                state        <= S_DATA;
                            end
                        end
                        if (fall) begin
                            header_valid <= 1'b0;
                            state        <= S_FLUSH;
                        end
                    end
                    S_DATA: begin
                        if (byte_keep) begin
                            rom_idx    <= rom_idx + 24'd1;
                            pend_valid <= !pend_valid;
                            pend_byte  <= rom_do;
                        end else if (data_byte) begin
                            overflow <= 1'b1;
                        end
                        if (push_drop) overflow <= 1'b1;
                        if (push_ok) rom_bytes <= rom_bytes + ((push_strb == 2'b11) ? 24'd2 : 24'd1);
                        if (fall) begin
                            pend_valid <= 1'b0;
                            state      <= S_FLUSH;
                        end
                    end
                    S_FLUSH: begin
                        if ((fifo_cnt == '0) && !mem.mem_req) begin
                            busy      <= 1'b0;
                            load_done <= 1'b1;
                            state     <= S_DONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef ROM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            checksum <= '0;
        end else if (rise) begin
            checksum <= '0;
        end else if (push_ok) begin
            checksum <= checksum + {8'h00, push_word[15:8]} + {8'h00, push_word[7:0]};
        end
    end
`else
    assign checksum = 16'h0000;
`endif

endmodule
